// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin arbiter sharing one memory port
// between NUM_CORES cores, with a per-transaction ready timeout.
module core_mem_arbiter #(
    parameter int MEM_WIDTH = 32,
    parameter int NUM_CORES = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CORES-1:0]           core_req,
    input  logic [NUM_CORES-1:0]           core_we,
    input  logic [NUM_CORES*MEM_WIDTH-1:0] core_addr,
    input  logic [NUM_CORES*MEM_WIDTH-1:0] core_wdata,
    output logic [NUM_CORES-1:0]           core_ack,
    output logic [MEM_WIDTH-1:0]           core_rdata,
    output logic                           core_err,
    output logic [MEM_WIDTH-1:0]           mem_addr,
    output logic [MEM_WIDTH-1:0]           mem_write_val,
    output logic                           mem_read_en,
    output logic                           mem_write_en,
    input  logic [MEM_WIDTH-1:0]           mem_read_val,
    input  logic                           mem_ready,
    output logic                           busy,
    output logic [$clog2(NUM_CORES)-1:0]   grant_id
);
    localparam int IDW = $clog2(NUM_CORES);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_CORES - 1);
    localparam logic [7:0]     CNT_END = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [IDW-1:0]       r_last;
    logic [IDW-1:0]       r_gid;
    logic                 r_we;
    logic [7:0]           r_cnt;
    logic [NUM_CORES-1:0] r_ack;
    logic [MEM_WIDTH-1:0] r_rdata;
    logic                 r_err;
    logic [MEM_WIDTH-1:0] r_addr;
    logic [MEM_WIDTH-1:0] r_wval;
    logic                 r_rd_en;
    logic                 r_wr_en;
    logic                 r_busy;

    logic                 w_found;
    logic [IDW-1:0]       w_win;
    logic [IDW-1:0]       w_cand;
    logic [MEM_WIDTH-1:0] w_addr_a  [NUM_CORES];
    logic [MEM_WIDTH-1:0] w_wdata_a [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign w_addr_a[g]  = core_addr[g*MEM_WIDTH +: MEM_WIDTH];
        assign w_wdata_a[g] = core_wdata[g*MEM_WIDTH +: MEM_WIDTH];
    end

    // Round-robin search: first requester after the last winner
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = r_last;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_cand = (w_cand == LAST_ID) ? '0 : w_cand + IDW'(1);
            if (!w_found && core_req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Transaction FSM; every output is a register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_last  <= LAST_ID;
            r_gid   <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wval  <= '0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gid   <= w_win;
                        r_we    <= core_we[w_win];
                        r_addr  <= w_addr_a[w_win];
                        r_wval  <= w_wdata_a[w_win];
                        r_rd_en <= !core_we[w_win];
                        r_wr_en <= core_we[w_win];
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b0;
                    r_cnt   <= r_cnt + 8'd1;
                    if (mem_ready) begin
                        r_rdata <= r_we ? '0 : mem_read_val;
                        r_err   <= 1'b0;
                        r_ack   <= NUM_CORES'(1) << r_gid;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_END) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_ack   <= NUM_CORES'(1) << r_gid;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    r_ack   <= '0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    r_last  <= r_gid;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_ack      = r_ack;
    assign core_rdata    = r_rdata;
    assign core_err      = r_err;
    assign mem_addr      = r_addr;
    assign mem_write_val = r_wval;
    assign mem_read_en   = r_rd_en;
    assign mem_write_en  = r_wr_en;
    assign busy          = r_busy;
    assign grant_id      = r_gid;

endmodule
